smart_cargo_movimento_uc: RTL and testbench
===========================================

Name: smart_cargo_movimento_uc

Overview:
Control unit that sequences the smart cargo elevator datapath through its operating cycle.
- Startup floor initialisation, travel toward the head-of-queue stop, floor-register updates on sensor edges, object load/unload, dwell timing and queue shift.
- Owns the motor commands and a travel watchdog that traps a stuck cabin.
- Sits beside the datapath; consumes its status flags and drives its enables.

Parameters:
TIMEOUT_ANDAR, 250000000, max clock cycles in MOVENDO without a floor-sensor edge before FALHA (5 s at 50 MHz)
W_WDOG, 28, watchdog counter width; must hold TIMEOUT_ANDAR-1

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
iniciar  in  1  start/resume request (level)
emergencia  in  1  emergency stop (level)
temDestino  in  1  queue head holds a valid entry
chegouDestino  in  1  head stop equals current floor
sobe  in  1  head stop above current floor
eh_origem_fila  in  1  head entry is a pickup (1) or delivery (0)
bordaSensorAtivo  in  1  one-cycle pulse, cabin reached a new floor
fimT  in  1  dwell timer expired
inicializa_andar  out  1  load approximate floor into floor register
enableAndarAtual  out  1  load fused floor into floor register
inicia_ultrasonico  out  1  enable ultrasonic measurement timer
zeraT  out  1  clear dwell timer
contaT  out  1  run dwell timer
coloca_objetos  out  1  write head object into cabin content RAM
tira_objetos  out  1  remove objects destined to current floor
shift  out  1  pop queue head
motor_sobe  out  1  drive cabin up
motor_desce  out  1  drive cabin down
porta_aberta  out  1  door open
falha  out  1  watchdog trap (sticky)
db_paradas  out  8  completed-stop count (see Optional Feature)
db_estado  out  4  current state code

Behaviour:
- All outputs Moore-decoded from registered state.
- Reset (async): state INICIAL; direction register, watchdog, db_paradas cleared; all outputs 0.
- States and codes:
  - INICIAL(0): wait iniciar=1 -> INICIALIZA(1).
  - INICIALIZA(1): inicializa_andar=1 for one cycle -> OCIOSO(2).
  - OCIOSO(2): temDestino=1 -> DECIDE(3).
  - DECIDE(3): chegouDestino=1 -> ABRE_PORTA(6). Else latch dir<=sobe -> MOVENDO(4).
  - MOVENDO(4):
    - motor_sobe=dir, motor_desce=~dir; watchdog increments each cycle.
    - bordaSensorAtivo -> ATUALIZA(5) and clears watchdog.
    - Watchdog == TIMEOUT_ANDAR-1 without an edge -> FALHA(B).
    - Edge and expiry in the same cycle: edge wins.
  - ATUALIZA(5): enableAndarAtual=1 for one cycle -> DECIDE. The new floor is visible to chegouDestino in DECIDE.
  - ABRE_PORTA(6): porta_aberta=1, zeraT=1 for one cycle -> CARGA(7).
  - CARGA(7): porta_aberta=1; coloca_objetos=eh_origem_fila, tira_objetos=~eh_origem_fila for exactly one cycle -> ESPERA(8).
  - ESPERA(8): porta_aberta=1, contaT=1; fimT -> PROXIMO(9).
  - PROXIMO(9): shift=1 for one cycle; db_paradas increments -> OCIOSO.
  - EMERGENCIA(A):
    - All motor/door/RAM strobes 0; watchdog cleared.
    - Exits to OCIOSO when emergencia=0 and iniciar=1; OCIOSO re-evaluates the queue.
  - FALHA(B): falha=1, all other outputs 0; leaves only via reset.
- inicia_ultrasonico=1 in every state except INICIAL, EMERGENCIA and FALHA.
- Priority: emergencia=1 in any state other than INICIAL/FALHA forces EMERGENCIA on the next edge. This overrides every other transition, including mid-CARGA; the one-cycle strobes are not repeated.
- Watchdog counts only in MOVENDO; held at 0 elsewhere.
- Unused codes C-F go to INICIAL on the next edge.

Optional Feature:
SMART_CARGO_CONTA_PARADAS_EN
- Defined: db_paradas is an 8-bit counter incremented on each PROXIMO cycle, saturating at 255, cleared by reset.
- Undefined: counter logic is omitted; db_paradas is tied to 0. The port is always present.

Test Plan:
- Startup: reset, iniciar=1 -> inicializa_andar high exactly 1 cycle; db_estado 0->1->2.
- Stop at current floor: temDestino=1, chegouDestino=1, eh_origem_fila=1, fimT pulsed 5 cycles after ESPERA entry -> zeraT 1 cycle, coloca_objetos 1 cycle, porta_aberta through ESPERA, shift 1 cycle, db_paradas=1 (macro on) / 0 (macro off).
- Travel two floors up, TIMEOUT_ANDAR=100:
  - Stimulus: sobe=1, chegouDestino=0; bordaSensorAtivo at cycles 20 and 40; chegouDestino=1 after the second edge.
  - Required: motor_sobe=1, motor_desce=0 throughout MOVENDO; enableAndarAtual pulses twice; then ABRE_PORTA.
- Watchdog, TIMEOUT_ANDAR=100: MOVENDO with no sensor edge -> FALHA entered exactly 100 cycles after MOVENDO entry. falha stays 1 and motors 0 despite iniciar/emergencia toggles until reset.
- Emergency mid-travel: emergencia=1 in MOVENDO -> motors 0 next cycle, db_estado=A. With emergencia=0 and iniciar=0 it stays in A; iniciar=1 -> OCIOSO.
- Async reset in ESPERA: reset asserted between edges -> all outputs 0 immediately, db_estado=0.

Source files
------------

// File: rtl/smart_cargo_movimento_uc_if.sv
// Status/command bundle between the elevator control unit and its datapath.
// The master side drives the status flags; the slave side (control unit) drives the enables.
interface smart_cargo_movimento_uc_if;
    logic       iniciar;
    logic       emergencia;
    logic       temDestino;
    logic       chegouDestino;
    logic       sobe;
    logic       eh_origem_fila;
    logic       bordaSensorAtivo;
    logic       fimT;
    logic       inicializa_andar;
    logic       enableAndarAtual;
    logic       inicia_ultrasonico;
    logic       zeraT;
    logic       contaT;
    logic       coloca_objetos;
    logic       tira_objetos;
    logic       shift;
    logic       motor_sobe;
    logic       motor_desce;
    logic       porta_aberta;
    logic       falha;
    logic [7:0] db_paradas;
    logic [3:0] db_estado;

    modport master (
        output iniciar, emergencia, temDestino, chegouDestino, sobe, eh_origem_fila,
               bordaSensorAtivo, fimT,
        input  inicializa_andar, enableAndarAtual, inicia_ultrasonico, zeraT, contaT,
               coloca_objetos, tira_objetos, shift, motor_sobe, motor_desce,
               porta_aberta, falha, db_paradas, db_estado
    );

    modport slave (
        input  iniciar, emergencia, temDestino, chegouDestino, sobe, eh_origem_fila,
               bordaSensorAtivo, fimT,
        output inicializa_andar, enableAndarAtual, inicia_ultrasonico, zeraT, contaT,
               coloca_objetos, tira_objetos, shift, motor_sobe, motor_desce,
               porta_aberta, falha, db_paradas, db_estado
    );
endinterface

// File: rtl/smart_cargo_movimento_uc.sv
// Smart cargo elevator control unit: sequences travel, load/unload, dwell and queue shift,
// with a travel watchdog. Define SMART_CARGO_CONTA_PARADAS_EN to enable the stop counter.
module smart_cargo_movimento_uc #(
    parameter int TIMEOUT_ANDAR = 250000000,
    parameter int W_WDOG        = 28
) (
    input  logic                        clock,
    input  logic                        reset,
    smart_cargo_movimento_uc_if.slave   bus
);

    typedef enum logic [3:0] {
        INICIAL    = 4'h0,
        INICIALIZA = 4'h1,
        OCIOSO     = 4'h2,
        DECIDE     = 4'h3,
        MOVENDO    = 4'h4,
        ATUALIZA   = 4'h5,
        ABRE_PORTA = 4'h6,
        CARGA      = 4'h7,
        ESPERA     = 4'h8,
        PROXIMO    = 4'h9,
        EMERGENCIA = 4'hA,
        FALHA      = 4'hB
    } t_estado;

    t_estado           r_state;
    logic              r_dir;
    logic [W_WDOG-1:0] r_wdog;

    t_estado           w_next;
    logic              w_dir;
    logic              w_wdog_fim;

    logic r_inicializa_andar, r_enableAndarAtual, r_inicia_ultrasonico;
    logic r_zeraT, r_contaT, r_coloca_objetos, r_tira_objetos, r_shift;
    logic r_motor_sobe, r_motor_desce, r_porta_aberta, r_falha;

    assign w_wdog_fim = (r_wdog == W_WDOG'(TIMEOUT_ANDAR - 1));

    always_comb begin
        w_next = r_state;
        w_dir  = r_dir;
        if (bus.emergencia && r_state != INICIAL && r_state != FALHA) begin
            w_next = EMERGENCIA;
        end else begin
            case (r_state)
                INICIAL:    if (bus.iniciar) w_next = INICIALIZA;
                INICIALIZA: w_next = OCIOSO;
                OCIOSO:     if (bus.temDestino) w_next = DECIDE;
                DECIDE: begin
                    if (bus.chegouDestino) begin
                        w_next = ABRE_PORTA;
                    end else begin
                        w_next = MOVENDO;
                        w_dir  = bus.sobe;
                    end
                end
                // A floor edge in the same cycle as watchdog expiry still counts as progress.
                MOVENDO: begin
                    if (bus.bordaSensorAtivo) w_next = ATUALIZA;
                    else if (w_wdog_fim)      w_next = FALHA;
                end
                ATUALIZA:   w_next = DECIDE;
                ABRE_PORTA: w_next = CARGA;
                CARGA:      w_next = ESPERA;
                ESPERA:     if (bus.fimT) w_next = PROXIMO;
                PROXIMO:    w_next = OCIOSO;
                EMERGENCIA: if (!bus.emergencia && bus.iniciar) w_next = OCIOSO;
                FALHA:      w_next = FALHA;
                default:    w_next = INICIAL;
            endcase
        end
    end

    // Outputs are decoded from the next state so they appear registered alongside it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state              <= INICIAL;
            r_dir                <= 1'b0;
            r_wdog               <= '0;
            r_inicializa_andar   <= 1'b0;
            r_enableAndarAtual   <= 1'b0;
            r_inicia_ultrasonico <= 1'b0;
            r_zeraT              <= 1'b0;
            r_contaT             <= 1'b0;
            r_coloca_objetos     <= 1'b0;
            r_tira_objetos       <= 1'b0;
            r_shift              <= 1'b0;
            r_motor_sobe         <= 1'b0;
            r_motor_desce        <= 1'b0;
            r_porta_aberta       <= 1'b0;
            r_falha              <= 1'b0;
        end else begin
            r_state <= w_next;
            r_dir   <= w_dir;
            r_wdog  <= (r_state == MOVENDO && w_next == MOVENDO) ? r_wdog + 1'b1 : '0;

            r_inicializa_andar   <= 1'b0;
            r_enableAndarAtual   <= 1'b0;
            r_inicia_ultrasonico <= !(w_next inside {INICIAL, EMERGENCIA, FALHA});
            r_zeraT              <= 1'b0;
            r_contaT             <= 1'b0;
            r_coloca_objetos     <= 1'b0;
            r_tira_objetos       <= 1'b0;
            r_shift              <= 1'b0;
            r_motor_sobe         <= 1'b0;
            r_motor_desce        <= 1'b0;
            r_porta_aberta       <= 1'b0;
            r_falha              <= 1'b0;
            case (w_next)
                INICIALIZA: r_inicializa_andar <= 1'b1;
                MOVENDO: begin
                    r_motor_sobe  <= w_dir;
                    r_motor_desce <= ~w_dir;
                end
                ATUALIZA:   r_enableAndarAtual <= 1'b1;
                ABRE_PORTA: begin
                    r_porta_aberta <= 1'b1;
                    r_zeraT        <= 1'b1;
                end
                CARGA: begin
                    r_porta_aberta   <= 1'b1;
                    r_coloca_objetos <= bus.eh_origem_fila;
                    r_tira_objetos   <= ~bus.eh_origem_fila;
                end
                ESPERA: begin
                    r_porta_aberta <= 1'b1;
                    r_contaT       <= 1'b1;
                end
                PROXIMO:    r_shift <= 1'b1;
                FALHA:      r_falha <= 1'b1;
                default:    ;
            endcase
        end
    end

`ifdef SMART_CARGO_CONTA_PARADAS_EN
    logic [7:0] r_paradas;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_paradas <= '0;
        else if (r_state == PROXIMO && r_paradas != 8'hFF)
            r_paradas <= r_paradas + 8'd1;
    end

    assign bus.db_paradas = r_paradas;
`else
    assign bus.db_paradas = 8'd0;
`endif

    assign bus.db_estado          = r_state;
    assign bus.inicializa_andar   = r_inicializa_andar;
    assign bus.enableAndarAtual   = r_enableAndarAtual;
    assign bus.inicia_ultrasonico = r_inicia_ultrasonico;
    assign bus.zeraT              = r_zeraT;
    assign bus.contaT             = r_contaT;
    assign bus.coloca_objetos     = r_coloca_objetos;
    assign bus.tira_objetos       = r_tira_objetos;
    assign bus.shift              = r_shift;
    assign bus.motor_sobe         = r_motor_sobe;
    assign bus.motor_desce        = r_motor_desce;
    assign bus.porta_aberta       = r_porta_aberta;
    assign bus.falha              = r_falha;

endmodule

// File: tb/tb_smart_cargo_movimento_uc.sv
// Bench for smart_cargo_movimento_uc: directed test-plan scenarios, then random stimulus
// checked every cycle against a behavioural state/timer model.
module tb_smart_cargo_movimento_uc;
    localparam int TMO = 100;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    smart_cargo_movimento_uc_if bus();

    smart_cargo_movimento_uc #(.TIMEOUT_ANDAR(TMO), .W_WDOG(28)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // reference model state
    int   m_state, m_wd, m_par;
    logic m_dir, m_eh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // {inicializa, enableAndar, ultrasonico, zeraT, contaT, coloca, tira, shift, m_sobe, m_desce, porta, falha}
    function automatic logic [11:0] outs_now();
        return {bus.inicializa_andar, bus.enableAndarAtual, bus.inicia_ultrasonico, bus.zeraT,
                bus.contaT, bus.coloca_objetos, bus.tira_objetos, bus.shift,
                bus.motor_sobe, bus.motor_desce, bus.porta_aberta, bus.falha};
    endfunction

    function automatic logic [11:0] exp_outs(input int st, input logic dir, input logic eh);
        logic [11:0] e;
        e    = '0;
        e[9] = !(st == 0 || st == 10 || st == 11);
        case (st)
            1:  e[11] = 1'b1;
            4:  begin e[3] = dir; e[2] = !dir; end
            5:  e[10] = 1'b1;
            6:  begin e[8] = 1'b1; e[1] = 1'b1; end
            7:  begin e[1] = 1'b1; e[6] = eh; e[5] = !eh; end
            8:  begin e[1] = 1'b1; e[7] = 1'b1; end
            9:  e[4] = 1'b1;
            11: e[0] = 1'b1;
            default: ;
        endcase
        return e;
    endfunction

    function automatic logic [7:0] exp_par(input int stops);
`ifdef SMART_CARGO_CONTA_PARADAS_EN
        return 8'(stops);
`else
        return 8'd0 & 8'(stops);
`endif
    endfunction

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic st(input string tag, input int s, input logic dir, input logic eh);
        chk({tag, "_estado"}, 32'(bus.db_estado), 32'(s));
        chk({tag, "_outs"}, 32'(outs_now()), 32'(exp_outs(s, dir, eh)));
    endtask

    task automatic set_in(input logic ini, em, tem, cheg, sb, eh, borda, fim);
        bus.iniciar = ini; bus.emergencia = em; bus.temDestino = tem; bus.chegouDestino = cheg;
        bus.sobe = sb; bus.eh_origem_fila = eh; bus.bordaSensorAtivo = borda; bus.fimT = fim;
    endtask

    // One clock of the spec's state machine, using the inputs currently driven.
    task automatic mdl_step();
        int ns;
        ns = m_state;
        if (bus.emergencia && m_state != 0 && m_state != 11) ns = 10;
        else begin
            case (m_state)
                0:  if (bus.iniciar) ns = 1;
                1:  ns = 2;
                2:  if (bus.temDestino) ns = 3;
                3:  if (bus.chegouDestino) ns = 6; else begin ns = 4; m_dir = bus.sobe; end
                4:  if (bus.bordaSensorAtivo) ns = 5; else if (m_wd == TMO - 1) ns = 11;
                5:  ns = 3;
                6:  ns = 7;
                7:  ns = 8;
                8:  if (bus.fimT) ns = 9;
                9:  ns = 2;
                10: if (!bus.emergencia && bus.iniciar) ns = 2;
                default: ns = 11;
            endcase
        end
        if (m_state == 9 && m_par < 255) m_par++;
        m_wd = (m_state == 4 && ns == 4) ? m_wd + 1 : 0;
        if (ns == 7) m_eh = bus.eh_origem_fila;
        m_state = ns;
    endtask

    initial begin
        int n_en;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        st("reset", 0, 0, 0);
        chk("reset_paradas", 32'(bus.db_paradas), 0);

        // startup
        reset = 1'b0;
        tick(); st("inicial_wait", 0, 0, 0);
        bus.iniciar = 1; tick(); st("inicializa", 1, 0, 0);
        bus.iniciar = 0; tick(); st("ocioso", 2, 0, 0);
        tick(); st("ocioso_hold", 2, 0, 0);

        // stop at current floor, pickup
        set_in(0, 0, 1, 1, 0, 1, 0, 0);
        tick(); st("stop_decide", 3, 0, 1);
        tick(); st("stop_abre", 6, 0, 1);
        tick(); st("stop_carga", 7, 0, 1);
        tick(); st("stop_espera", 8, 0, 1);
        repeat (4) begin tick(); st("stop_espera_hold", 8, 0, 1); end
        bus.fimT = 1; tick(); st("stop_proximo", 9, 0, 1);
        bus.fimT = 0; bus.temDestino = 0; tick(); st("stop_ocioso", 2, 0, 1);
        chk("stop_paradas", 32'(bus.db_paradas), 32'(exp_par(1)));

        // travel two floors up
        set_in(0, 0, 1, 0, 1, 1, 0, 0);
        tick(); st("trav_decide", 3, 0, 0);
        tick(); st("trav_mov", 4, 1, 0);
        n_en = 0;
        for (int p = 0; p < 2; p++) begin
            repeat (18) begin tick(); st("trav_mov_hold", 4, 1, 0); end
            bus.bordaSensorAtivo = 1; tick(); st("trav_atualiza", 5, 1, 0);
            n_en += int'(bus.enableAndarAtual);
            bus.bordaSensorAtivo = 0;
            if (p == 1) bus.chegouDestino = 1;
            tick(); st("trav_redecide", 3, 1, 0);
            if (p == 0) begin tick(); st("trav_mov2", 4, 1, 0); end
        end
        chk("trav_en_pulses", 32'(n_en), 2);
        tick(); st("trav_abre", 6, 1, 1);
        tick(); st("trav_carga", 7, 1, 1);
        tick(); st("trav_espera", 8, 1, 1);
        bus.fimT = 1; tick(); st("trav_proximo", 9, 1, 1);
        bus.fimT = 0; bus.temDestino = 0; tick(); st("trav_ocioso", 2, 1, 1);
        chk("trav_paradas", 32'(bus.db_paradas), 32'(exp_par(2)));

        // watchdog: moving down with no floor edge
        set_in(0, 0, 1, 0, 0, 1, 0, 0);
        tick(); st("wd_decide", 3, 0, 0);
        tick(); st("wd_mov", 4, 0, 0);
        repeat (TMO - 1) begin tick(); st("wd_mov_hold", 4, 0, 0); end
        tick(); st("wd_falha", 11, 0, 0);
        for (int i = 0; i < 6; i++) begin
            bus.iniciar = i[0]; bus.emergencia = i[1];
            tick(); st("wd_falha_sticky", 11, 0, 0);
        end
        reset = 1'b1; set_in(0, 0, 0, 0, 0, 0, 0, 0);
        tick(); st("wd_reset", 0, 0, 0);
        reset = 1'b0;

        // emergency while moving
        bus.iniciar = 1; tick(); st("em_ini", 1, 0, 0);
        bus.iniciar = 0; tick(); st("em_ocioso", 2, 0, 0);
        set_in(0, 0, 1, 0, 1, 0, 0, 0);
        tick(); st("em_decide", 3, 0, 0);
        tick(); st("em_mov", 4, 1, 0);
        bus.emergencia = 1; tick(); st("em_enter", 10, 0, 0);
        bus.emergencia = 0;
        repeat (3) begin tick(); st("em_hold", 10, 0, 0); end
        bus.iniciar = 1; tick(); st("em_exit", 2, 0, 0);
        bus.iniciar = 0; bus.temDestino = 0; tick(); st("em_ocioso2", 2, 0, 0);

        // async reset during dwell, delivery stop
        set_in(0, 0, 1, 1, 0, 0, 0, 0);
        tick(); st("ar_decide", 3, 0, 0);
        tick(); st("ar_abre", 6, 0, 0);
        tick(); st("ar_carga", 7, 0, 0);
        tick(); st("ar_espera", 8, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk("ar_outs", 32'(outs_now()), 0);
        chk("ar_estado", 32'(bus.db_estado), 0);
        chk("ar_paradas", 32'(bus.db_paradas), 0);
        tick();

        // random phase
        m_state = 0; m_wd = 0; m_par = 0; m_dir = 0; m_eh = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 499) begin
                reset = 1'b1;
                set_in(0, 0, 0, 0, 0, 0, 0, 0);
                m_state = 0; m_wd = 0; m_par = 0; m_dir = 0;
            end else begin
                reset = 1'b0;
                bus.iniciar          = ($urandom_range(0, 3) != 0);
                bus.emergencia       = ($urandom_range(0, 39) == 0);
                bus.temDestino       = 1'($urandom_range(0, 1));
                bus.chegouDestino    = ($urandom_range(0, 2) == 0);
                bus.sobe             = 1'($urandom_range(0, 1));
                bus.bordaSensorAtivo = ($urandom_range(0, 5) == 0);
                bus.fimT             = ($urandom_range(0, 3) == 0);
                if (m_state != 6 && m_state != 7) bus.eh_origem_fila = 1'($urandom_range(0, 1));
                mdl_step();
            end
            tick();
            chk("rnd_estado", 32'(bus.db_estado), 32'(m_state));
            chk("rnd_outs", 32'(outs_now()), 32'(exp_outs(m_state, m_dir, m_eh)));
            chk("rnd_paradas", 32'(bus.db_paradas), 32'(exp_par(m_par)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
